rope_stream_engine: RTL and testbench
=====================================

Name: rope_stream_engine

Overview:
- Streaming rotary-position-embedding (RoPE) engine; next generation of the PosEmb datapath.
- Joins a data beat stream (TOUT channels of one token of one head) with a pos-table stream (cos/sin per channel pair) and emits rotated beats.
- Generalised over lanes, heads, tokens and channel groups per head, with KV-cache token offset, bypass mode and a config range check.
- Sits between the HBM read DMA (data and pos channels) and the write DMA.

Parameters:
- TOUT, 32, channels per beat (even).
- DW, 16, signed data element width.
- POS_DW, 16, signed cos/sin element width.
- POS_FRAC, 14, fraction bits of cos/sin (range 1 <= POS_FRAC <= POS_DW-1).
- MAX_HEAD, 32, max heads per job.
- MAX_TOKEN, 2048, pos-table rows.
- MAX_GROUP, 8, max channel groups (CH_per_head/TOUT) per head.

Ports:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cfg_start  in  1  start pulse; sampled in IDLE only.
- cfg_heads  in  clog2(MAX_HEAD+1)  head count.
- cfg_tokens  in  clog2(MAX_TOKEN+1)  tokens per head.
- cfg_tok_base  in  clog2(MAX_TOKEN)  first pos row (KV-cache offset).
- cfg_groups  in  clog2(MAX_GROUP+1)  beats per token.
- cfg_bypass  in  1  1 = pass data unrotated.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  config rejected; sticky until next accepted cfg_start.
- in_valid/in_ready  in/out  1  data handshake.
- in_data  in  TOUT*DW  lane k at bits [k*DW +: DW].
- pos_valid/pos_ready  in/out  1  pos handshake.
- pos_data  in  TOUT*POS_DW  lanes 0..TOUT/2-1 hold cos, lanes TOUT/2..TOUT-1 hold sin.
- pos_addr  out  clog2(MAX_TOKEN*MAX_GROUP)  pos beat index the next fire consumes.
- out_valid/out_ready  out/in  1  output handshake.
- out_data  out  TOUT*DW  rotated beat.
- out_last  out  1  last beat of a head.

Behaviour:
- Reset: busy, done, error, in_ready, pos_ready, out_valid, out_last, pos_addr, out_data = 0; state = IDLE; all pipeline valids cleared. Reset mid-job aborts the job with no done pulse.
- States:
  - IDLE: on cfg_start, latch config and clear error.
    - If heads==0, tokens==0, groups==0, groups>MAX_GROUP, heads>MAX_HEAD, or tok_base+tokens>MAX_TOKEN: set error, pulse done next cycle, stay IDLE, consume nothing.
    - Otherwise go to RUN, busy=1, pos_addr=tok_base*groups.
  - RUN: counters grp (fastest), tok, head.
    - Fire = in_valid && in_ready && (bypass || pos_valid).
    - pos_ready = in_ready when not bypass, else 0.
    - Each fire: pos_addr+1. On tok wrap at end of head, pos_addr reloads tok_base*groups.
    - After the fire of the final beat (heads*tokens*groups total), go to DRAIN with in_ready=0.
  - DRAIN: wait for the final out fire; then busy=0, done=1 for one cycle, go to IDLE.
- cfg_start outside IDLE is ignored.
- Pipeline: 2 stages, global enable en = !out_valid || out_ready.
  - in_ready = (state==RUN) && en && beats_remaining.
  - Latency: fire in cycle N gives out_valid in cycle N+2 when not stalled.
  - Full throughput of 1 beat/cycle. No beat is dropped or duplicated under any backpressure pattern.
- out_last accompanies the beat with grp==groups-1 and tok==tokens-1.
- Arithmetic, per pair i (x0=lane 2i, x1=lane 2i+1, c=cos lane i, s=sin lane i, pair i uses pos lane i):
  - S1 registers the four signed products, each DW+POS_DW bits.
  - S2 computes y0 = x0*c - x1*s and y1 = x0*s + x1*c at width DW+POS_DW+1.
  - Add 2^(POS_FRAC-1), then arithmetic shift right by POS_FRAC (round half up).
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
- Bypass: data passes through the same 2-stage delay unmodified. pos_addr still counts; pos stream is not consumed.

Decomposition:
- rope_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - width localparams derived via clog2;
  - a round_sat function (width-parameterised via DW/POS_FRAC constants).
- Sub-module rope_rotate_pair: one 2-stage pair datapath with enable and bypass. The top instantiates TOUT/2 copies via generate.
- The top holds the FSM, counters, address register and handshake.

Test Plan:
- Identity: c=16384, s=0, heads=2, tokens=3, groups=2, x lanes = 0..31 -> 12 beats out equal to the input. pos_addr sequence is 0..5, then 0..5 again for head 1. out_last is high on beats 6 and 12. done pulses once.
- Rotation and KV offset: tok_base=100, groups=1, x pair (3,5), c=0, s=16384 -> out (-5,3). First pos_addr is 100.
- Saturation and rounding:
  - x=(32767,-32768), c=s=16384 -> (32767,-1).
  - x=(1,0), c=8192 -> 1.
  - x=(-1,0), c=8192 -> 0.
- Backpressure: random out_ready (50%) and random in_valid/pos_valid gaps on a 64-beat job -> output equals the golden model in order. No loss or duplication; in_ready stays 0 while out_valid && !out_ready.
- Config reject: tok_base=2040, tokens=9 -> error=1 and done one cycle after start, in_ready stays 0. The next valid start clears error.
- Reset mid-job: assert rst after beat 5 of 12 -> all outputs 0 immediately, no done. A fresh job afterwards completes correctly.

Source files
------------

// File: rtl/rope_pkg.sv
// rtl/rope_pkg.sv - shared widths, FSM state type and rounding helper for the RoPE stream engine.
package rope_pkg;
  localparam int TOUT      = 32;
  localparam int DW        = 16;
  localparam int POS_DW    = 16;
  localparam int POS_FRAC  = 14;
  localparam int MAX_HEAD  = 32;
  localparam int MAX_TOKEN = 2048;
  localparam int MAX_GROUP = 8;

  localparam int PAIRS  = TOUT / 2;
  localparam int HEAD_W = $clog2(MAX_HEAD + 1);
  localparam int TOK_W  = $clog2(MAX_TOKEN + 1);
  localparam int BASE_W = $clog2(MAX_TOKEN);
  localparam int GRP_W  = $clog2(MAX_GROUP + 1);
  localparam int ADDR_W = $clog2(MAX_TOKEN * MAX_GROUP);
  localparam int PROD_W = DW + POS_DW;
  localparam int ACC_W  = PROD_W + 1;

  localparam logic signed [ACC_W:0] RND_C   = (ACC_W + 1)'(2 ** (POS_FRAC - 1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] r;
    r = $signed({v[ACC_W-1], v}) + RND_C;
    r = r >>> POS_FRAC;
    if (r > SAT_MAX) begin
      r = SAT_MAX;
    end else if (r < SAT_MIN) begin
      r = SAT_MIN;
    end
    return r[DW-1:0];
  endfunction
endpackage

// File: rtl/rope_rotate_pair.sv
// rtl/rope_rotate_pair.sv - two-stage rotation of one channel pair (products, then sum/round/saturate).
module rope_rotate_pair
  import rope_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     bypass,
  input  logic signed [DW-1:0]     x0_i,
  input  logic signed [DW-1:0]     x1_i,
  input  logic signed [POS_DW-1:0] c_i,
  input  logic signed [POS_DW-1:0] s_i,
  output logic signed [DW-1:0]     y0_o,
  output logic signed [DW-1:0]     y1_o
);
  logic signed [PROD_W-1:0] x0c_q, x1s_q, x0s_q, x1c_q;
  logic signed [PROD_W-1:0] x0c_d, x1s_d, x0s_d, x1c_d;
  logic signed [DW-1:0]     x0_q, x1_q, x0_d, x1_d;
  logic signed [DW-1:0]     y0_q, y1_q, y0_d, y1_d;
  logic signed [ACC_W-1:0]  acc0, acc1;

  always_comb begin
    x0c_d = PROD_W'(x0_i) * PROD_W'(c_i);
    x1s_d = PROD_W'(x1_i) * PROD_W'(s_i);
    x0s_d = PROD_W'(x0_i) * PROD_W'(s_i);
    x1c_d = PROD_W'(x1_i) * PROD_W'(c_i);
    x0_d  = x0_i;
    x1_d  = x1_i;
    acc0  = ACC_W'(x0c_q) - ACC_W'(x1s_q);
    acc1  = ACC_W'(x0s_q) + ACC_W'(x1c_q);
    // Raw data rides alongside the products so bypass keeps the same latency.
    y0_d  = bypass ? x0_q : round_sat(acc0);
    y1_d  = bypass ? x1_q : round_sat(acc1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0c_q <= '0;
      x1s_q <= '0;
      x0s_q <= '0;
      x1c_q <= '0;
      x0_q  <= '0;
      x1_q  <= '0;
      y0_q  <= '0;
      y1_q  <= '0;
    end else if (en) begin
      x0c_q <= x0c_d;
      x1s_q <= x1s_d;
      x0s_q <= x0s_d;
      x1c_q <= x1c_d;
      x0_q  <= x0_d;
      x1_q  <= x1_d;
      y0_q  <= y0_d;
      y1_q  <= y1_d;
    end
  end

  assign y0_o = y0_q;
  assign y1_o = y1_q;
endmodule

// File: rtl/rope_stream_engine.sv
// rtl/rope_stream_engine.sv - RoPE stream engine top: job FSM, head/token/group counters, pos addressing, handshake.
module rope_stream_engine
  import rope_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [HEAD_W-1:0]        cfg_heads,
  input  logic [TOK_W-1:0]         cfg_tokens,
  input  logic [BASE_W-1:0]        cfg_tok_base,
  input  logic [GRP_W-1:0]         cfg_groups,
  input  logic                     cfg_bypass,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TOUT*DW-1:0]       in_data,
  input  logic                     pos_valid,
  output logic                     pos_ready,
  input  logic [TOUT*POS_DW-1:0]   pos_data,
  output logic [ADDR_W-1:0]        pos_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TOUT*DW-1:0]       out_data,
  output logic                     out_last
);
  state_e              state_q, state_d;
  logic [HEAD_W-1:0]   heads_q, heads_d, head_q, head_d;
  logic [TOK_W-1:0]    tokens_q, tokens_d, tok_q, tok_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [GRP_W-1:0]    groups_q, groups_d, grp_q, grp_d;
  logic                bypass_q, bypass_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                v1_q, v1_d, v2_q, v2_d;
  logic                last1_q, last1_d, last2_q, last2_d;
  logic                done_q, done_d, error_q, error_d;

  logic                en, fire, cfg_bad;
  logic                grp_last, tok_last, head_last;
  logic [TOK_W:0]      span;
  logic [ADDR_W-1:0]   base_addr, start_addr;

  assign en        = !v2_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && en;
  assign pos_ready = in_ready && !bypass_q;
  assign fire      = in_valid && in_ready && (bypass_q || pos_valid);

  assign grp_last  = (grp_q == groups_q - GRP_W'(1));
  assign tok_last  = (tok_q == tokens_q - TOK_W'(1));
  assign head_last = (head_q == heads_q - HEAD_W'(1));

  assign span       = (TOK_W + 1)'(cfg_tok_base) + (TOK_W + 1)'(cfg_tokens);
  assign start_addr = ADDR_W'(cfg_tok_base) * ADDR_W'(cfg_groups);
  assign base_addr  = ADDR_W'(base_q) * ADDR_W'(groups_q);
  assign cfg_bad    = (cfg_heads == '0) || (cfg_tokens == '0) || (cfg_groups == '0) ||
                      (cfg_groups > GRP_W'(MAX_GROUP)) || (cfg_heads > HEAD_W'(MAX_HEAD)) ||
                      (span > (TOK_W + 1)'(MAX_TOKEN));

  always_comb begin
    state_d  = state_q;
    heads_d  = heads_q;
    tokens_d = tokens_q;
    base_d   = base_q;
    groups_d = groups_q;
    bypass_d = bypass_q;
    head_d   = head_q;
    tok_d    = tok_q;
    grp_d    = grp_q;
    addr_d   = addr_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    last1_d  = last1_q;
    last2_d  = last2_q;
    done_d   = 1'b0;
    error_d  = error_q;

    if (en) begin
      v1_d    = fire;
      last1_d = fire && grp_last && tok_last;
      v2_d    = v1_q;
      last2_d = last1_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          heads_d  = cfg_heads;
          tokens_d = cfg_tokens;
          base_d   = cfg_tok_base;
          groups_d = cfg_groups;
          bypass_d = cfg_bypass;
          error_d  = cfg_bad;
          if (cfg_bad) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            head_d  = '0;
            tok_d   = '0;
            grp_d   = '0;
            addr_d  = start_addr;
          end
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (!grp_last) begin
            grp_d  = grp_q + GRP_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            grp_d = '0;
            if (!tok_last) begin
              tok_d  = tok_q + TOK_W'(1);
              addr_d = addr_q + ADDR_W'(1);
            end else begin
              // Every head revisits the same pos rows starting at the KV offset.
              tok_d  = '0;
              addr_d = base_addr;
              if (head_last) begin
                head_d  = '0;
                state_d = ST_DRAIN;
              end else begin
                head_d = head_q + HEAD_W'(1);
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        if (v2_q && out_ready && !v1_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      heads_q  <= '0;
      tokens_q <= '0;
      base_q   <= '0;
      groups_q <= '0;
      bypass_q <= 1'b0;
      head_q   <= '0;
      tok_q    <= '0;
      grp_q    <= '0;
      addr_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      last1_q  <= 1'b0;
      last2_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      heads_q  <= heads_d;
      tokens_q <= tokens_d;
      base_q   <= base_d;
      groups_q <= groups_d;
      bypass_q <= bypass_d;
      head_q   <= head_d;
      tok_q    <= tok_d;
      grp_q    <= grp_d;
      addr_q   <= addr_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      last1_q  <= last1_d;
      last2_q  <= last2_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  for (genvar i = 0; i < PAIRS; i++) begin : g_pair
    rope_rotate_pair u_pair (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .bypass (bypass_q),
      .x0_i   (in_data[(2*i)*DW +: DW]),
      .x1_i   (in_data[(2*i+1)*DW +: DW]),
      .c_i    (pos_data[i*POS_DW +: POS_DW]),
      .s_i    (pos_data[(PAIRS+i)*POS_DW +: POS_DW]),
      .y0_o   (out_data[(2*i)*DW +: DW]),
      .y1_o   (out_data[(2*i+1)*DW +: DW])
    );
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign pos_addr  = addr_q;
  assign out_valid = v2_q;
  assign out_last  = last2_q;
endmodule

// File: tb/tb_rope_stream_engine.sv
// tb/tb_rope_stream_engine.sv - directed self-checking bench for rope_stream_engine.
module tb_rope_stream_engine;
  import rope_pkg::*;

  typedef logic [TOUT*DW-1:0]     vec_t;
  typedef logic [TOUT*POS_DW-1:0] pvec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [HEAD_W-1:0] cfg_heads;
  logic [TOK_W-1:0]  cfg_tokens;
  logic [BASE_W-1:0] cfg_tok_base;
  logic [GRP_W-1:0]  cfg_groups;
  logic              cfg_bypass;
  logic              busy, done, error;
  logic              in_valid, in_ready, pos_valid, pos_ready;
  vec_t              in_data, out_data;
  pvec_t             pos_data;
  logic [ADDR_W-1:0] pos_addr;
  logic              out_valid, out_ready, out_last;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   fire_cyc, out_cyc, d0, k, b, guard;
  vec_t  bx  [0:127];
  pvec_t bp  [0:127];
  vec_t  cap [0:127];

  int rj_h [6] = '{0, 1, 1, 1, 33, 1};
  int rj_t [6] = '{1, 0, 1, 1, 1, 9};
  int rj_b [6] = '{0, 0, 0, 0, 0, 2040};
  int rj_g [6] = '{1, 1, 0, 9, 1, 1};

  rope_stream_engine dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_heads(cfg_heads), .cfg_tokens(cfg_tokens),
    .cfg_tok_base(cfg_tok_base), .cfg_groups(cfg_groups), .cfg_bypass(cfg_bypass),
    .busy(busy), .done(done), .error(error), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
    .pos_addr(pos_addr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_v(input string tag, input vec_t obs, input vec_t exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] clamp(input longint y);
    longint r;
    r = (y + (64'sd1 <<< (POS_FRAC - 1))) >>> POS_FRAC;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[DW-1:0];
  endfunction

  function automatic vec_t model(input vec_t x, input pvec_t p);
    vec_t r;
    longint a0, a1, c, s;
    r = '0;
    for (int i = 0; i < PAIRS; i++) begin
      a0 = $signed(x[(2*i)*DW +: DW]);
      a1 = $signed(x[(2*i+1)*DW +: DW]);
      c  = $signed(p[i*POS_DW +: POS_DW]);
      s  = $signed(p[(PAIRS+i)*POS_DW +: POS_DW]);
      r[(2*i)*DW +: DW]   = clamp(a0 * c - a1 * s);
      r[(2*i+1)*DW +: DW] = clamp(a0 * s + a1 * c);
    end
    return r;
  endfunction

  function automatic pvec_t pos_all(input logic [15:0] c, input logic [15:0] s);
    pvec_t r;
    for (int i = 0; i < PAIRS; i++) begin
      r[i*POS_DW +: POS_DW]         = c;
      r[(PAIRS+i)*POS_DW +: POS_DW] = s;
    end
    return r;
  endfunction

  task automatic fill_random(input int n);
    for (int j = 0; j < n; j++) begin
      for (int w = 0; w < TOUT*DW/32; w++) begin
        bx[j][w*32 +: 32] = $urandom;
        bp[j][w*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic fill_identity();
    for (int j = 0; j < 12; j++) begin
      for (int l = 0; l < TOUT; l++) bx[j][l*DW +: DW] = DW'(j * 32 + l);
      bp[j] = pos_all(16'd16384, 16'd0);
    end
  endtask

  task automatic drive_beats(input int n, input int t, input int base, input int g,
                             input bit byp, input bit rnd);
    int bi, gd;
    bi = 0;
    gd = 0;
    while (bi < n && gd < 4000) begin
      @(posedge clk); #1;
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pos_valid = byp ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = bx[bi];
      pos_data  = bp[bi];
      @(negedge clk);
      if (in_valid && in_ready && (byp || pos_valid)) begin
        chk_i("pos_addr", int'(pos_addr), (base + (bi / g) % t) * g + bi % g);
        chk_b("pos_ready", pos_ready, !byp);
        if (bi == 0) fire_cyc = cyc;
        bi++;
      end
      gd++;
    end
    chk_i("drive_count", bi, n);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    pos_valid = 1'b0;
  endtask

  task automatic sink_beats(input int n, input int t, input int g,
                            input bit byp, input bit rnd, input bit ident);
    int ki, gd;
    vec_t e;
    ki = 0;
    gd = 0;
    while (ki < n && gd < 4000) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && !out_ready) chk_b("stall_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        e = (byp || ident) ? bx[ki] : model(bx[ki], bp[ki]);
        chk_v("out_data", out_data, e);
        chk_b("out_last", out_last, (ki % (t * g)) == (t * g - 1));
        cap[ki] = out_data;
        if (ki == 0) out_cyc = cyc;
        ki++;
      end
      gd++;
    end
    chk_i("sink_count", ki, n);
    @(posedge clk); #1;
    chk_b("done_pulse", done, 1'b1);
    chk_b("busy_end", busy, 1'b0);
    chk_b("no_extra_beat", out_valid, 1'b0);
    @(posedge clk); #1;
    chk_b("done_clear", done, 1'b0);
    out_ready = 1'b1;
  endtask

  task automatic run_job(input int h, input int t, input int base, input int g,
                         input bit byp, input bit rnd, input bit ident);
    int dc;
    cfg_heads    = HEAD_W'(h);
    cfg_tokens   = TOK_W'(t);
    cfg_tok_base = BASE_W'(base);
    cfg_groups   = GRP_W'(g);
    cfg_bypass   = byp;
    dc = done_cnt;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    chk_b("busy_start", busy, 1'b1);
    chk_b("error_clear", error, 1'b0);
    chk_i("first_addr", int'(pos_addr), base * g);
    fork
      drive_beats(h * t * g, t, base, g, byp, rnd);
      sink_beats(h * t * g, t, g, byp, rnd, ident);
    join
    chk_i("done_count", done_cnt - dc, 1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_heads = '0; cfg_tokens = '0; cfg_tok_base = '0; cfg_groups = '0;
    cfg_bypass = 1'b0; in_valid = 1'b0; pos_valid = 1'b0; in_data = '0; pos_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_error", error, 1'b0);
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_pos_ready", pos_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_out_last", out_last, 1'b0);
    chk_i("rst_pos_addr", int'(pos_addr), 0);
    chk_v("rst_out_data", out_data, '0);
    @(negedge clk) rst = 1'b0;

    fill_identity();
    run_job(2, 3, 0, 2, 1'b0, 1'b0, 1'b1);
    chk_i("latency", out_cyc - fire_cyc, 2);

    for (int i = 0; i < 6; i++) begin
      cfg_heads    = HEAD_W'(rj_h[i]);
      cfg_tokens   = TOK_W'(rj_t[i]);
      cfg_tok_base = BASE_W'(rj_b[i]);
      cfg_groups   = GRP_W'(rj_g[i]);
      in_valid = 1'b1;
      pos_valid = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b1;
      @(posedge clk); #1 cfg_start = 1'b0;
      chk_b("rej_error", error, 1'b1);
      chk_b("rej_done", done, 1'b1);
      chk_b("rej_busy", busy, 1'b0);
      chk_b("rej_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk_b("rej_done_clear", done, 1'b0);
      chk_b("rej_error_sticky", error, 1'b1);
      chk_b("rej_idle_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    pos_valid = 1'b0;

    fill_random(1);
    bx[0][15:0]  = 16'd3;
    bx[0][31:16] = 16'd5;
    bp[0] = pos_all(16'd0, 16'd16384);
    run_job(1, 1, 100, 1, 1'b0, 1'b0, 1'b0);
    chk_i("rot_y0", int'($signed(cap[0][15:0])), -5);
    chk_i("rot_y1", int'($signed(cap[0][31:16])), 3);

    for (int j = 0; j < 3; j++) bx[j] = '0;
    bx[0][15:0]  = 16'h7fff;
    bx[0][31:16] = 16'h8000;
    bp[0] = pos_all(16'd16384, 16'd16384);
    bx[1][15:0] = 16'd1;
    bp[1] = pos_all(16'd8192, 16'd0);
    bx[2][15:0] = 16'hffff;
    bp[2] = pos_all(16'd8192, 16'd0);
    run_job(1, 3, 0, 1, 1'b0, 1'b0, 1'b0);
    chk_i("sat_y0", int'($signed(cap[0][15:0])), 32767);
    chk_i("sat_y1", int'($signed(cap[0][31:16])), -1);
    chk_i("round_pos", int'($signed(cap[1][15:0])), 1);
    chk_i("round_neg", int'($signed(cap[2][15:0])), 0);

    fill_random(64);
    run_job(2, 4, 5, 8, 1'b0, 1'b1, 1'b0);

    fill_random(8);
    run_job(1, 8, 2040, 1, 1'b0, 1'b1, 1'b0);

    fill_random(4);
    run_job(1, 2, 3, 2, 1'b1, 1'b1, 1'b0);

    fill_identity();
    cfg_heads = HEAD_W'(2); cfg_tokens = TOK_W'(3); cfg_tok_base = '0; cfg_groups = GRP_W'(2);
    cfg_bypass = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    k = 0;
    b = 0;
    guard = 0;
    while (k < 5 && guard < 200) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      pos_valid = 1'b1;
      in_data = bx[b];
      pos_data = bp[b];
      @(negedge clk);
      if (in_valid && in_ready) b++;
      if (out_valid && out_ready) k++;
      guard++;
    end
    chk_i("rst_reach_beat5", k, 5);
    #2 rst = 1'b1;
    #1;
    d0 = done_cnt;
    chk_b("mid_rst_busy", busy, 1'b0);
    chk_b("mid_rst_done", done, 1'b0);
    chk_b("mid_rst_error", error, 1'b0);
    chk_b("mid_rst_in_ready", in_ready, 1'b0);
    chk_b("mid_rst_pos_ready", pos_ready, 1'b0);
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    chk_b("mid_rst_out_last", out_last, 1'b0);
    chk_i("mid_rst_pos_addr", int'(pos_addr), 0);
    chk_v("mid_rst_out_data", out_data, '0);
    in_valid = 1'b0;
    pos_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_i("mid_rst_no_done", done_cnt - d0, 0);
    chk_b("mid_rst_idle", busy, 1'b0);
    run_job(2, 3, 0, 2, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
